// File: rtl/jk_bank_driver_if.sv
// rtl/jk_bank_driver_if.sv - command handshake and check status bundle for jk_bank_driver
//
// Purpose: groups the command valid/ready handshake with the per-command
// check results (busy, done, q_expected, mismatch).
// Ports (signals):
//   cmd_valid, cmd_op[2:0], cmd_data[WIDTH-1:0]  : command from initiator
//   cmd_ready                                    : driver can accept a command
//   busy, done, q_expected[WIDTH-1:0], mismatch  : check status from driver
// Modports: master = command initiator, slave = jk_bank_driver.
interface jk_bank_driver_if #(
  parameter int WIDTH = 4
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q_expected;
  logic             mismatch;

  modport master (
    output cmd_valid, cmd_op, cmd_data,
    input  cmd_ready, busy, done, q_expected, mismatch
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_data,
    output cmd_ready, busy, done, q_expected, mismatch
  );
endinterface

// File: rtl/jk_bank_driver.sv
// rtl/jk_bank_driver.sv - stimulus/check driver for a bank of JK master-slave flip-flops
//
// Purpose: accepts one command at a time, turns it into J/K excitations plus a
// timed ff_clk pulse (sync ops) or a preset/clear pulse (async ops), then
// compares the bank readback against the expected value.
// Ports:
//   clk          : system clock, rising edge
//   clr          : asynchronous active-high reset
//   cmd          : jk_bank_driver_if.slave (handshake + check status)
//   j_out, k_out : J/K inputs to the bank
//   ff_clk       : clock to the bank
//   pre_bar_out  : bank preset, active low
//   clr_bar_out  : bank clear, active low
//   q_in         : bank Q readback
// Optional feature: define JK_BANK_DRIVER_QSYNC_EN to pass q_in through a
// 2-flop synchronizer and insert a 2-cycle WAIT state before CHECK.
module jk_bank_driver #(
  parameter int WIDTH         = 4,
  parameter int SETTLE_CYCLES = 2,
  parameter int PULSE_CYCLES  = 2
) (
  input  logic              clk,
  input  logic              clr,
  jk_bank_driver_if.slave   cmd,
  output logic [WIDTH-1:0]  j_out,
  output logic [WIDTH-1:0]  k_out,
  output logic              ff_clk,
  output logic              pre_bar_out,
  output logic              clr_bar_out,
  input  logic [WIDTH-1:0]  q_in
);

  localparam int CMAX = (SETTLE_CYCLES > PULSE_CYCLES) ?
                        ((SETTLE_CYCLES > 2) ? SETTLE_CYCLES : 2) :
                        ((PULSE_CYCLES > 2) ? PULSE_CYCLES : 2);
  localparam int CW = $clog2(CMAX + 1);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_SETUP, S_HIGH, S_LOW, S_ASYNC, S_WAIT, S_CHECK
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_use;

`ifdef JK_BANK_DRIVER_QSYNC_EN
  logic [WIDTH-1:0] q_s1, q_s2;
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_s1 <= '0;
      q_s2 <= '0;
    end else begin
      q_s1 <= q_in;
      q_s2 <= q_s1;
    end
  end
  assign q_use = q_s2;
`else
  assign q_use = q_in;
`endif

  // Excitation and expected value for the command currently offered;
  // q_use at the accept edge is the snapshot the op is applied to.
  logic [WIDTH-1:0] j_nxt, k_nxt, exp_nxt, q_inc, q_dec;
  logic             is_async, async_pre;

  always_comb begin
    q_inc     = q_use + WIDTH'(1);
    q_dec     = q_use - WIDTH'(1);
    j_nxt     = '0;
    k_nxt     = '0;
    exp_nxt   = q_use;
    is_async  = 1'b0;
    async_pre = 1'b0;
    case (cmd.cmd_op)
      3'b001: begin
        j_nxt   = cmd.cmd_data;
        k_nxt   = ~cmd.cmd_data;
        exp_nxt = cmd.cmd_data;
      end
      3'b010: begin
        // J=K=1 toggles exactly the bits that differ from the snapshot
        j_nxt   = q_use ^ q_inc;
        k_nxt   = q_use ^ q_inc;
        exp_nxt = q_inc;
      end
      3'b011: begin
        j_nxt   = q_use ^ q_dec;
        k_nxt   = q_use ^ q_dec;
        exp_nxt = q_dec;
      end
      3'b100: begin
        j_nxt   = '1;
        k_nxt   = '1;
        exp_nxt = ~q_use;
      end
      3'b101: begin
        is_async  = 1'b1;
        async_pre = 1'b1;
        exp_nxt   = '1;
      end
      3'b110: begin
        is_async = 1'b1;
        exp_nxt  = '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state          <= S_INIT;
      cnt            <= '0;
      ff_clk         <= 1'b0;
      j_out          <= '0;
      k_out          <= '0;
      pre_bar_out    <= 1'b1;
      clr_bar_out    <= 1'b0;
      cmd.cmd_ready  <= 1'b0;
      cmd.busy       <= 1'b0;
      cmd.done       <= 1'b0;
      cmd.q_expected <= '0;
      cmd.mismatch   <= 1'b0;
    end else begin
      cmd.done <= 1'b0;
      case (state)
        S_INIT: begin
          clr_bar_out   <= 1'b1;
          cmd.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
        S_IDLE: begin
          if (cmd.cmd_valid) begin
            cmd.cmd_ready  <= 1'b0;
            cmd.busy       <= 1'b1;
            cmd.q_expected <= exp_nxt;
            cnt            <= '0;
            if (is_async) begin
              pre_bar_out <= ~async_pre;
              clr_bar_out <= async_pre;
              state       <= S_ASYNC;
            end else begin
              j_out <= j_nxt;
              k_out <= k_nxt;
              state <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt    <= '0;
            ff_clk <= 1'b1;
            state  <= S_HIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_HIGH: begin
          if (cnt == CW'(PULSE_CYCLES - 1)) begin
            cnt    <= '0;
            ff_clk <= 1'b0;
            state  <= S_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_ASYNC: begin
          if (cnt == CW'(PULSE_CYCLES - 1)) begin
            cnt         <= '0;
            pre_bar_out <= 1'b1;
            clr_bar_out <= 1'b1;
            state       <= S_LOW;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOW: begin
          if (cnt == CW'(SETTLE_CYCLES - 1)) begin
            cnt   <= '0;
            j_out <= '0;
            k_out <= '0;
`ifdef JK_BANK_DRIVER_QSYNC_EN
            state <= S_WAIT;
`else
            state <= S_CHECK;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          // lets the settled Q travel through the synchronizer
          if (cnt == CW'(1)) begin
            cnt   <= '0;
            state <= S_CHECK;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_CHECK: begin
          cmd.mismatch  <= (q_use != cmd.q_expected);
          cmd.done      <= 1'b1;
          cmd.busy      <= 1'b0;
          cmd.cmd_ready <= 1'b1;
          state         <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// tb/tb_jk_bank_driver.sv - directed self-checking bench for jk_bank_driver
module tb_jk_bank_driver;
  localparam int W = 4;
`ifdef JK_BANK_DRIVER_QSYNC_EN
  localparam int EXTRA = 2;
`else
  localparam int EXTRA = 0;
`endif
  localparam int LAT_SYNC  = 7 + EXTRA;
  localparam int LAT_ASYNC = 5 + EXTRA;

  logic         clk = 1'b0;
  logic         clr = 1'b1;
  logic [W-1:0] j_out, k_out, q_in;
  logic [W-1:0] q_bank = '0;
  logic         ff_clk, pre_bar_out, clr_bar_out;
  logic         stuck = 1'b0;

  int checks = 0;
  int errors = 0;

  int lat, ff_hi, pre_lo, clrb_lo, pulses, viol, wait_n;
  logic [W-1:0] j_seen, k_seen;
  logic busy_seen, done_seen;

  jk_bank_driver_if #(.WIDTH(W)) cmd_if ();

  jk_bank_driver #(
    .WIDTH(W), .SETTLE_CYCLES(2), .PULSE_CYCLES(2)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .cmd         (cmd_if),
    .j_out       (j_out),
    .k_out       (k_out),
    .ff_clk      (ff_clk),
    .pre_bar_out (pre_bar_out),
    .clr_bar_out (clr_bar_out),
    .q_in        (q_in)
  );

  always #5 clk = ~clk;

  // master-slave JK bank: output follows J/K on the falling clock edge
  always @(negedge ff_clk or negedge pre_bar_out or negedge clr_bar_out) begin
    if (clr_bar_out === 1'b0) q_bank <= '0;
    else if (pre_bar_out === 1'b0) q_bank <= '1;
    else if (ff_clk === 1'b0) begin
      for (int i = 0; i < W; i++) begin
        case ({j_out[i], k_out[i]})
          2'b01:   q_bank[i] <= 1'b0;
          2'b10:   q_bank[i] <= 1'b1;
          2'b11:   q_bank[i] <= ~q_bank[i];
          default: ;
        endcase
      end
    end
  end

  assign q_in = stuck ? (q_bank & 4'b1110) : q_bank;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one command and watches it until done; the accept edge is cycle 0.
  task automatic run_cmd(input logic [2:0] op, input logic [3:0] data, input bit keep);
    logic prev;
    wait_n = 0;
    while (!cmd_if.cmd_ready && wait_n < 40) begin
      step();
      wait_n++;
    end
    check("cmd_ready_before_issue", cmd_if.cmd_ready, 1);
    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_data  = data;
    step();
    if (!keep) cmd_if.cmd_valid = 1'b0;
    j_seen = j_out; k_seen = k_out; busy_seen = cmd_if.busy;
    ff_hi = 0; pre_lo = 0; clrb_lo = 0; pulses = 0; viol = 0; lat = -1; prev = 1'b0;
    for (int c = 1; c <= 40 && lat < 0; c++) begin
      if (ff_clk) ff_hi++;
      if (ff_clk && !prev) pulses++;
      prev = ff_clk;
      if (!pre_bar_out) pre_lo++;
      if (!clr_bar_out) clrb_lo++;
      if (ff_clk && (!pre_bar_out || !clr_bar_out)) viol++;
      if (!pre_bar_out && !clr_bar_out) viol++;
      step();
      if (cmd_if.done) lat = c;
    end
  endtask

  initial begin
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = 3'b000;
    cmd_if.cmd_data  = '0;

    @(negedge clk);
    check("rst_ff_clk", ff_clk, 0);
    check("rst_pre_bar", pre_bar_out, 1);
    check("rst_clr_bar", clr_bar_out, 0);
    check("rst_cmd_ready", cmd_if.cmd_ready, 0);
    check("rst_busy", cmd_if.busy, 0);
    check("rst_q_expected", cmd_if.q_expected, 0);
    check("rst_mismatch", cmd_if.mismatch, 0);
    clr = 1'b0;
    #1;
    check("init_clr_bar_low", clr_bar_out, 0);
    check("init_not_ready", cmd_if.cmd_ready, 0);
    step();
    check("idle_clr_bar_high", clr_bar_out, 1);
    check("idle_cmd_ready", cmd_if.cmd_ready, 1);
    step();
    check("idle_bank_q", q_in, 0);
    check("idle_mismatch", cmd_if.mismatch, 0);

    run_cmd(3'b001, 4'b1010, 1'b0);
    check("load_latency", lat, LAT_SYNC);
    check("load_busy", busy_seen, 1);
    check("load_j", j_seen, 4'b1010);
    check("load_k", k_seen, 4'b0101);
    check("load_pulses", pulses, 1);
    check("load_ff_high_cycles", ff_hi, 2);
    check("load_q_expected", cmd_if.q_expected, 4'b1010);
    check("load_mismatch", cmd_if.mismatch, 0);
    check("load_bank_q", q_in, 4'b1010);
    check("load_busy_after", cmd_if.busy, 0);
    check("load_jk_released", {j_out, k_out}, 0);

    run_cmd(3'b001, 4'b1111, 1'b0);
    check("load1111_bank_q", q_in, 4'b1111);
    run_cmd(3'b010, 4'b0000, 1'b0);
    check("inc_wrap_j", j_seen, 4'b1111);
    check("inc_wrap_k", k_seen, 4'b1111);
    check("inc_wrap_bank_q", q_in, 4'b0000);
    check("inc_wrap_q_expected", cmd_if.q_expected, 4'b0000);
    check("inc_wrap_mismatch", cmd_if.mismatch, 0);
    run_cmd(3'b011, 4'b0000, 1'b0);
    check("dec_wrap_j", j_seen, 4'b1111);
    check("dec_wrap_bank_q", q_in, 4'b1111);
    check("dec_wrap_q_expected", cmd_if.q_expected, 4'b1111);

    run_cmd(3'b001, 4'b0110, 1'b0);
    run_cmd(3'b010, 4'b0000, 1'b0);
    check("inc_0110_j", j_seen, 4'b0001);
    check("inc_0110_bank_q", q_in, 4'b0111);
    run_cmd(3'b010, 4'b0000, 1'b0);
    check("inc_0111_j", j_seen, 4'b1111);
    check("inc_0111_bank_q", q_in, 4'b1000);
    check("inc_0111_mismatch", cmd_if.mismatch, 0);

    run_cmd(3'b101, 4'b0000, 1'b1);
    check("preset_latency", lat, LAT_ASYNC);
    check("preset_pre_low_cycles", pre_lo, 2);
    check("preset_clr_low_cycles", clrb_lo, 0);
    check("preset_ff_high", ff_hi, 0);
    check("preset_invariants", viol, 0);
    check("preset_bank_q", q_in, 4'b1111);
    check("preset_q_expected", cmd_if.q_expected, 4'b1111);
    run_cmd(3'b110, 4'b0000, 1'b0);
    check("clear_b2b_wait", wait_n, 0);
    check("clear_latency", lat, LAT_ASYNC);
    check("clear_clr_low_cycles", clrb_lo, 2);
    check("clear_pre_low_cycles", pre_lo, 0);
    check("clear_ff_high", ff_hi, 0);
    check("clear_invariants", viol, 0);
    check("clear_bank_q", q_in, 4'b0000);

    run_cmd(3'b111, 4'b1111, 1'b0);
    check("op7_j", j_seen, 4'b0000);
    check("op7_q_expected", cmd_if.q_expected, 4'b0000);
    check("op7_bank_q", q_in, 4'b0000);

    stuck = 1'b1;
    run_cmd(3'b100, 4'b0000, 1'b0);
    check("toggle_j", j_seen, 4'b1111);
    check("toggle_k", k_seen, 4'b1111);
    check("toggle_q_expected", cmd_if.q_expected, 4'b1111);
    check("toggle_q_in", q_in, 4'b1110);
    check("toggle_mismatch", cmd_if.mismatch, 1);
    repeat (3) step();
    check("toggle_mismatch_held", cmd_if.mismatch, 1);
    stuck = 1'b0;
    run_cmd(3'b000, 4'b0000, 1'b0);
    check("hold_q_expected", cmd_if.q_expected, 4'b1111);
    check("hold_mismatch_cleared", cmd_if.mismatch, 0);

    cmd_if.cmd_valid = 1'b1;
    cmd_if.cmd_op    = 3'b010;
    step();
    cmd_if.cmd_valid = 1'b0;
    wait_n = 0;
    while (!ff_clk && wait_n < 20) begin
      step();
      wait_n++;
    end
    check("abort_reached_high", ff_clk, 1);
    clr = 1'b1;
    #1;
    check("abort_ff_clk", ff_clk, 0);
    check("abort_busy", cmd_if.busy, 0);
    check("abort_clr_bar", clr_bar_out, 0);
    done_seen = 1'b0;
    repeat (2) begin
      step();
      done_seen = done_seen | cmd_if.done;
    end
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("abort_init_clr_bar", clr_bar_out, 0);
    step();
    done_seen = done_seen | cmd_if.done;
    check("abort_no_done", done_seen, 0);
    check("abort_idle_clr_bar", clr_bar_out, 1);
    check("abort_cmd_ready", cmd_if.cmd_ready, 1);
    check("abort_bank_q", q_in, 4'b0000);
    check("abort_mismatch", cmd_if.mismatch, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
